// File: rtl/ula_pkg.sv
// Shared op encodings, FSM states and constants for the multi-cycle ALU.
package ula_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_SLTU = 4'b0101,
        OP_SLT  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRA  = 4'b1010,
        OP_MUL  = 4'b1100,
        OP_DIVU = 4'b1110,
        OP_REMU = 4'b1111
    } ula_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } ula_state_t;

    localparam int unsigned ULA_OP_DEFAULT_RESULT = 0;

endpackage

// File: rtl/ula_multiciclo_if.sv
// Operand/result valid-ready bus between register-file read, the ALU and writeback.
interface ula_multiciclo_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic [3:0]       ULAControl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ULAResult;
    logic             Z;

    modport master (
        output in_valid, SrcA, SrcB, ULAControl, out_ready,
        input  in_ready, out_valid, ULAResult, Z
    );

    modport slave (
        input  in_valid, SrcA, SrcB, ULAControl, out_ready,
        output in_ready, out_valid, ULAResult, Z
    );
endinterface

// File: rtl/ula_muldiv_iter.sv
// Radix-2 iterative multiply (shift-add) and unsigned restoring divide/remainder.
// Only instantiated when ULA_MULDIV_EN is defined.
module ula_muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_mul,
    input  logic             is_rem,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c
);
    localparam int unsigned CW = $clog2(WIDTH);

    logic             busy;
    logic [CW-1:0]    count;
    logic             mul_q;
    logic             rem_q;
    // mul: x=multiplicand, y=multiplier, acc=product
    // div: x=divisor, y=dividend shifting into quotient, acc=partial remainder
    logic [WIDTH-1:0] x, y, acc;
    logic [WIDTH-1:0] x_n, y_n, acc_n;
    logic [WIDTH:0]   shifted_c, diff_c;

    // One step of the selected algorithm
    always_comb begin
        shifted_c = {acc, y[WIDTH-1]};
        diff_c    = shifted_c - {1'b0, x};
        x_n       = x;
        y_n       = y;
        acc_n     = acc;
        if (mul_q) begin
            if (y[0]) acc_n = acc + x;
            x_n = x << 1;
            y_n = y >> 1;
        end else if (!diff_c[WIDTH]) begin
            acc_n = diff_c[WIDTH-1:0];
            y_n   = {y[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = shifted_c[WIDTH-1:0];
            y_n   = {y[WIDTH-2:0], 1'b0};
        end
        result_c = (mul_q || rem_q) ? acc_n : y_n;
        done_c   = busy && (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
            mul_q <= 1'b0;
            rem_q <= 1'b0;
            x     <= '0;
            y     <= '0;
            acc   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            mul_q <= is_mul;
            rem_q <= is_rem;
            x     <= is_mul ? a : b;
            y     <= is_mul ? b : a;
            acc   <= '0;
        end else if (busy) begin
            x     <= x_n;
            y     <= y_n;
            acc   <= acc_n;
            count <= count + CW'(1);
            if (done_c) busy <= 1'b0;
        end
    end
endmodule

// File: rtl/ula_multiciclo.sv
// Registered multi-cycle ALU with valid/ready handshake on both sides.
// ULA_MULDIV_EN adds the iterative MUL/DIVU/REMU path; without it those codes yield 0.
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    ula_multiciclo_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    ula_state_t       state;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             z_q;
    logic [WIDTH-1:0] alu_c;
    logic [SHW-1:0]   shamt_c;
    logic             go_calc_c;

    // Single-cycle results, straight from the presented operands
    always_comb begin
        alu_c   = WIDTH'(ULA_OP_DEFAULT_RESULT);
        shamt_c = bus.SrcB[SHW-1:0];
        case (bus.ULAControl)
            OP_ADD:  alu_c = bus.SrcA + bus.SrcB;
            OP_SUB:  alu_c = bus.SrcA - bus.SrcB;
            OP_AND:  alu_c = bus.SrcA & bus.SrcB;
            OP_OR:   alu_c = bus.SrcA | bus.SrcB;
            OP_XOR:  alu_c = bus.SrcA ^ bus.SrcB;
            OP_SLTU: alu_c = WIDTH'(bus.SrcA < bus.SrcB);
            OP_SLT:  alu_c = WIDTH'($signed(bus.SrcA) < $signed(bus.SrcB));
            OP_SRL:  alu_c = bus.SrcA >> shamt_c;
            OP_SLL:  alu_c = bus.SrcA << shamt_c;
            OP_SRA:  alu_c = $signed(bus.SrcA) >>> shamt_c;
            default: ;
        endcase
    end

`ifdef ULA_MULDIV_EN
    logic             start_c;
    logic             it_done_c;
    logic [WIDTH-1:0] it_result_c;

    assign go_calc_c = (bus.ULAControl == OP_MUL) || (bus.ULAControl == OP_DIVU)
                    || (bus.ULAControl == OP_REMU);
    assign start_c   = (state == IDLE) && bus.in_valid && go_calc_c;

    ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (start_c),
        .is_mul   (bus.ULAControl == OP_MUL),
        .is_rem   (bus.ULAControl == OP_REMU),
        .a        (bus.SrcA),
        .b        (bus.SrcB),
        .done_c   (it_done_c),
        .result_c (it_result_c)
    );
`else
    assign go_calc_c = 1'b0;
`endif

    // Control FSM with registered handshake and result
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            z_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (go_calc_c) begin
                            state <= CALC;
                        end else begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_c;
                            z_q         <= (alu_c == '0);
                        end
                    end
                end
`ifdef ULA_MULDIV_EN
                CALC: begin
                    if (it_done_c) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= it_result_c;
                        z_q         <= (it_result_c == '0);
                    end
                end
`endif
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ULAResult = result_q;
    assign bus.Z         = z_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Scoreboard bench for ula_multiciclo; expectations follow ULA_MULDIV_EN when defined.
module tb_ula_multiciclo;
    import ula_pkg::*;

`ifdef ULA_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t it;
    bit   prev_v = 1'b0;

    ula_multiciclo_if #(.WIDTH(32)) bus ();

    ula_multiciclo #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] md_exp(input logic [31:0] v);
        return MD ? v : 32'h0;
    endfunction

    function automatic int md_lat();
        return MD ? 33 : 1;
    endfunction

    // Present an op once the block is ready; push its expectation on accept
    task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] er, input int lat);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({nm, "_accept_timeout"}, 32'(bus.in_ready), 32'd1);
        bus.SrcA = a;
        bus.SrcB = b;
        bus.ULAControl = op;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        sb.push_back('{res: er, z: (er == 32'h0), lat: lat, acc: cyc, nm: nm});
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: checks latency on first valid cycle, result/Z every valid cycle, pops on handshake
    always @(negedge clk) begin
        if (reset) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    it = sb[0];
                    if (!prev_v) chk({it.nm, "_latency"}, 32'(cyc - it.acc), 32'(it.lat - 1));
                    chk({it.nm, "_result"}, bus.ULAResult, it.res);
                    chk({it.nm, "_z"}, 32'(bus.Z), 32'(it.z));
                    if (bus.out_ready) void'(sb.pop_front());
                end
            end
            prev_v = bus.out_valid && !bus.out_ready;
        end
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.SrcA = '0;
        bus.SrcB = '0;
        bus.ULAControl = 4'b0000;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.ULAResult, 32'h0);
        chk("rst_z", 32'(bus.Z), 32'd0);
        bus.out_ready = 1'b1;

        issue("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        issue("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        issue("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        issue("sra", OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
        issue("sub", OP_SUB, 32'h5, 32'h7, 32'hFFFF_FFFE, 1);
        issue("and", OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        issue("xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1);
        issue("sll", OP_SLL, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        issue("srl", OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1);
        issue("unsupported", 4'b0100, 32'h1234, 32'h5678, 32'h0, 1);
        wait_drain();

        issue("mul", OP_MUL, 32'h0001_0003, 32'h0002_0005, md_exp(32'h000B_000F), md_lat());
        n = 0;
        while (!bus.out_valid && n < 40) begin
            chk("mul_in_ready_busy", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        wait_drain();
        issue("divu", OP_DIVU, 32'd100, 32'd7, md_exp(32'd14), md_lat());
        issue("remu", OP_REMU, 32'd100, 32'd7, md_exp(32'd2), md_lat());
        issue("divu_by0", OP_DIVU, 32'd5, 32'd0, md_exp(32'hFFFF_FFFF), md_lat());
        issue("remu_by0", OP_REMU, 32'd5, 32'd0, md_exp(32'd5), md_lat());
        wait_drain();

        // Backpressure: result held, extra in_valid ignored, then release
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue("hold_or", OP_OR, 32'hF0, 32'h0F, 32'hFF, 1);
        bus.SrcA = 32'h1;
        bus.SrcB = 32'h1;
        bus.ULAControl = OP_ADD;
        bus.in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during an op discards it
        bus.out_ready = 1'b0;
        issue("abort_divu", OP_DIVU, 32'd100, 32'd7, md_exp(32'd14), md_lat());
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_result", bus.ULAResult, 32'h0);
        bus.out_ready = 1'b1;
        issue("add_after_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
